// File: rtl/img_pkg.sv
// img_pkg: shared constants, FSM encoding and read-mask helper for the image line-buffer controller
package img_pkg;
  localparam int IMG_W = 512;
  localparam int N_LB = 4;
  localparam int PIX_W = 8;
  localparam int KERNEL = 3;
  localparam int TAP_W = PIX_W * KERNEL;
  localparam int OCC_W = 12;
  typedef enum logic {IDLE = 1'b0, RD = 1'b1} state_e;
  function automatic logic [N_LB-1:0] rd_mask(input logic [1:0] r);
    logic [2*N_LB-1:0] t;
    t = {4'b0111, 4'b0111} << r;
    return t[2*N_LB-1:N_LB];
  endfunction
endpackage

// File: rtl/img_ctrl_if.sv
// img_ctrl_if: pixel stream, line-buffer and window signals of the controller
interface img_ctrl_if;
  import img_pkg::*;
  logic [PIX_W-1:0] i_pixel_data;
  logic i_pixel_data_valid;
  logic [N_LB-1:0] o_lb_wr_valid;
  logic [PIX_W-1:0] o_lb_wr_data;
  logic [N_LB-1:0] o_lb_rd_en;
  logic [TAP_W-1:0] i_lb0_data;
  logic [TAP_W-1:0] i_lb1_data;
  logic [TAP_W-1:0] i_lb2_data;
  logic [TAP_W-1:0] i_lb3_data;
  logic [KERNEL*TAP_W-1:0] o_pixel_data;
  logic o_pixel_data_valid;
  logic o_intr;
  modport slave (
    input i_pixel_data, i_pixel_data_valid, i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data,
    output o_lb_wr_valid, o_lb_wr_data, o_lb_rd_en, o_pixel_data, o_pixel_data_valid, o_intr
  );
  modport master (
    output i_pixel_data, i_pixel_data_valid, i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data,
    input o_lb_wr_valid, o_lb_wr_data, o_lb_rd_en, o_pixel_data, o_pixel_data_valid, o_intr
  );
endinterface

// File: rtl/img_ctrl.sv
// img_ctrl: round-robin line-buffer writer and 3-line reader producing a 3x3 pixel window
module img_ctrl #(
  parameter int IMG_W = img_pkg::IMG_W,
  parameter int N_LB = img_pkg::N_LB
) (
  input logic i_clk,
  input logic i_rst,
  img_ctrl_if.slave bus
);
  import img_pkg::*;
  localparam int CW = $clog2(IMG_W);
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  state_e state_q, state_d;
  logic intr_q, wr, rd, rd_done;
  logic [N_LB-1:0][TAP_W-1:0] lb;
  assign wr = bus.i_pixel_data_valid;
  assign rd = state_q == RD;
  assign rd_done = rd && rd_cnt_q == CW'(IMG_W - 1);
  assign lb = {bus.i_lb3_data, bus.i_lb2_data, bus.i_lb1_data, bus.i_lb0_data};
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      occ_q <= '0;
      intr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      occ_q <= occ_d;
      intr_q <= rd_done;
    end
  end
  // a simultaneous write and read leaves occupancy unchanged
  always_comb begin
    wr_cnt_d = wr_cnt_q + CW'(wr);
    wr_idx_d = wr_idx_q + 2'(wr && wr_cnt_q == CW'(IMG_W - 1));
    rd_cnt_d = rd_cnt_q + CW'(rd);
    rd_idx_d = rd_idx_q + 2'(rd_done);
    occ_d = occ_q + OCC_W'(wr && !rd) - OCC_W'(rd && !wr);
  end
  // start reading on the edge that registers three full lines
  always_comb begin
    state_d = rd ? (rd_done ? IDLE : RD) : (occ_d >= OCC_W'(3 * IMG_W) ? RD : IDLE);
  end
  always_comb begin
    bus.o_lb_wr_valid = N_LB'(wr) << wr_idx_q;
    bus.o_lb_wr_data = bus.i_pixel_data;
    bus.o_lb_rd_en = rd ? rd_mask(rd_idx_q) : '0;
    bus.o_pixel_data = {lb[rd_idx_q], lb[rd_idx_q + 2'd1], lb[rd_idx_q + 2'd2]};
    bus.o_pixel_data_valid = rd;
    bus.o_intr = intr_q;
  end
endmodule

// File: tb/tb_img_ctrl.sv
// tb_img_ctrl: randomized directed bench checking img_ctrl against a pixel-count reference model
module tb_img_ctrl;
  localparam int W = 512;
  logic clk = 1'b0;
  logic rst = 1'b0;
  img_ctrl_if bus();
  img_ctrl #(.IMG_W(W), .N_LB(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int wtot = 0;
  int rtot = 0;
  bit m_rd = 1'b0;
  bit m_intr = 1'b0;
  logic [23:0] lbv [4];
  logic o_valid_s, o_intr_s;
  logic [3:0] o_en_s;
  logic [71:0] o_pix_s;
  logic [71:0] first_pix;
  logic [23:0] first_lb [4];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  function automatic logic [3:0] exp_en(input int r);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < 3; k++) m[(r + k) % 4] = 1'b1;
    return m;
  endfunction

  // one clock: drive, check against model, then advance the model at the edge
  task automatic cycle(input bit v, input bit rs);
    int r, w;
    logic [7:0] px;
    px = 8'($urandom);
    rst = rs;
    bus.i_pixel_data_valid = v;
    bus.i_pixel_data = px;
    for (int k = 0; k < 4; k++) lbv[k] = 24'($urandom);
    bus.i_lb0_data = lbv[0];
    bus.i_lb1_data = lbv[1];
    bus.i_lb2_data = lbv[2];
    bus.i_lb3_data = lbv[3];
    #1;
    r = (rtot / W) % 4;
    w = (wtot / W) % 4;
    o_valid_s = bus.o_pixel_data_valid;
    o_intr_s = bus.o_intr;
    o_en_s = bus.o_lb_rd_en;
    o_pix_s = bus.o_pixel_data;
    chk("wr_valid", bus.o_lb_wr_valid, v ? 4'(1 << w) : 4'b0);
    chk("wr_data", bus.o_lb_wr_data, px);
    chk("rd_valid", o_valid_s, m_rd);
    chk("rd_en", o_en_s, m_rd ? exp_en(r) : 4'b0);
    chk("window", o_pix_s, {lbv[r], lbv[(r + 1) % 4], lbv[(r + 2) % 4]});
    chk("intr", o_intr_s, m_intr);
    if (v && rs && wtot == 2048) chk("wr_wrap", bus.o_lb_wr_valid, 4'b0001);
    @(posedge clk);
    if (!rs) begin
      wtot = 0;
      rtot = 0;
      m_rd = 1'b0;
      m_intr = 1'b0;
    end else begin
      m_intr = m_rd && (rtot % W == W - 1);
      wtot += int'(v);
      if (m_rd) begin
        rtot++;
        if (rtot % W == 0) m_rd = 1'b0;
      end else if (wtot - rtot >= 3 * W) m_rd = 1'b1;
    end
    checks++;
    assert (wtot - rtot <= 4 * W) else begin
      errors++;
      $error("FAIL occ_limit observed=%0d expected<=%0d", wtot - rtot, 4 * W);
    end
    #1;
  endtask

  task automatic fill(input int n);
    int sent;
    bit v;
    sent = 0;
    for (int g = 0; g < 8 * n + 16 && sent < n; g++) begin
      v = $urandom_range(0, 3) != 0;
      cycle(v, 1'b1);
      sent += int'(v);
    end
    if (sent < n) chk("fill_timeout", 72'(sent), 72'(n));
  endtask

  task automatic read_period(input bit v, input logic [3:0] expd_en);
    int n, g;
    g = 0;
    while (!m_rd && g < 8) begin
      cycle(1'b0, 1'b1);
      g++;
    end
    chk("rd_start", 72'(m_rd), 72'(1));
    cycle(v, 1'b1);
    first_pix = o_pix_s;
    first_lb = lbv;
    chk("rd_en_first", o_en_s, expd_en);
    n = int'(o_valid_s);
    g = 0;
    while (m_rd && g < W + 8) begin
      cycle(v, 1'b1);
      n += int'(o_valid_s);
      g++;
    end
    chk("rd_len", 72'(n), 72'(W));
    cycle(1'b0, 1'b1);
    chk("intr_pulse", o_intr_s, 1'b1);
    chk("valid_after", o_valid_s, 1'b0);
  endtask

  initial begin
    bus.i_pixel_data_valid = 1'b0;
    bus.i_pixel_data = '0;
    bus.i_lb0_data = '0;
    bus.i_lb1_data = '0;
    bus.i_lb2_data = '0;
    bus.i_lb3_data = '0;
    @(posedge clk);
    #1;
    repeat (3) cycle(1'b0, 1'b0);
    chk("rst_outputs", {o_valid_s, o_intr_s, o_en_s, bus.o_lb_wr_valid}, '0);
    cycle(1'b1, 1'b0);
    fill(1535);
    cycle(1'b0, 1'b1);
    chk("no_rd_1535", o_valid_s, 1'b0);
    fill(1);
    read_period(1'b0, 4'b0111);
    cycle(1'b0, 1'b1);
    chk("intr_once", o_intr_s, 1'b0);
    fill(512);
    read_period(1'b1, 4'b1110);
    chk("win_r1", first_pix, {first_lb[1], first_lb[2], first_lb[3]});
    read_period(1'b0, 4'b1101);
    fill(512);
    read_period(1'b0, 4'b1011);
    chk("win_r3", first_pix, {first_lb[3], first_lb[0], first_lb[1]});
    fill(512);
    for (int g = 0; g < 200; g++) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("mid_rst_valid", o_valid_s, 1'b0);
    chk("mid_rst_intr", o_intr_s, 1'b0);
    chk("mid_rst_en", o_en_s, 4'b0);
    fill(1536);
    read_period(1'b0, 4'b0111);
    chk("win_r0", first_pix, {first_lb[0], first_lb[1], first_lb[2]});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
